fphub_adder_pipe: RTL and testbench
===================================

// Module: fphub_adder_pipe
// PURPOSE
// - Pipelined HUB floating-point adder/subtractor; successor to the combinational FPHUB adder.
// - Generalised over E/M; adds a per-operation add/sub mode, valid/ready handshake with backpressure, and status flags.
// - Sits between operand issue logic and the result writeback/FIFO in the FPHUB datapath.
// - Fixed 3-stage pipeline:
//   - S1: classify operands, compare, swap, align.
//   - S2: add or subtract the mantissas; run the LZD.
//   - S3: normalise, saturate, pack.
// PARAMETERS
// M  23  stored mantissa bits; the HUB ILSB (implicit 1) is appended internally
// E   8  exponent bits; the E field is all-zero or all-ones for special operands
// PORTS
// clk        in   1      clock, rising edge
// rst_n      in   1      asynchronous active-low reset
// in_valid   in   1      operand pair valid
// in_ready   out  1      block accepts operands this cycle
// x          in   E+M+1  operand X: {sign, exp, mant}
// y          in   E+M+1  operand Y
// op_sub     in   1      1: Z = X - Y (invert Y sign before processing); 0: Z = X + Y
// out_valid  out  1      z/flags valid
// out_ready  in   1      consumer accepts the result this cycle
// z          out  E+M+1  result
// flags      out  3      {ovf, unf, spec}; spec = special-case path taken
// BEHAVIOUR
// Reset (async, rst_n=0):
// - All stage valid bits, out_valid, z and flags reset to 0; in_ready = 1 from the first cycle after release.
// Handshake:
// - Transfer on in_valid&in_ready, and on out_valid&out_ready.
// - in_ready = ~v3 | out_ready. Whole-pipe stall: when in_ready=0, every stage holds.
// - Bubbles do not compress.
// - z/flags stay stable while out_valid & ~out_ready.
// - Latency is 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
// Classification (after the op_sub sign flip of Y):
// - ZERO: exp field = 0. MAX: exp field = all-ones.
// - X ZERO, Y ZERO -> +0, spec=1.
// - Exactly one ZERO -> the other operand unchanged, spec=1.
// - Any MAX (takes priority over ZERO) -> {sign of the MAX operand, X's if both, all-ones exp+mant}, ovf=1, spec=1.
// Normal path, major/minor selection:
// - Major = larger exponent; on equal exponents, the larger mantissa. Ez = major exponent.
// - Mantissas are extended as {0, 1, mant, 1}, M+3 bits.
// Alignment:
// - Minor is logically right-shifted by |Ex-Ey|.
// - A shift >= M+3 yields a minor of 0.
// Mantissa arithmetic:
// - Effective subtraction when the signs differ: major minus minor. The result is never negative.
// - Otherwise major plus minor.
// - Sign Sz = major sign.
// Normalisation, add:
// - If the carry bit [M+2] is set: shift right 1, Ez+1.
// - If Ez+1 reaches all-ones: saturate to {Sz, all-ones}, ovf=1.
// Normalisation, sub:
// - Shift left by LZD count L, Ez-L.
// - If Ez <= L, or the mantissa result is 0: output +0, unf=1 (exact cancellation sets unf=0).
// Pack:
// - z = {Sz, Ez, res[M:1]}; the ILSB bit[0] is dropped, with no rounding (HUB).
// - flags are cleared on the normal path except as stated above.
// Boundary cases:
// - Reset mid-operation discards in-flight results; no out_valid pulse is produced.
// - Simultaneous accept and drain while full (out_ready=1) advances the pipe with no bubble.
// TESTING
// (E=8, M=23)
// - Add: x=0x3F800000, y=0x3F800000, op_sub=0 -> z=0x40000000 after 3 cycles, flags=000.
// - Cancel: x=0x40490FDB, y=0x40490FDB, op_sub=1 -> z=0x00000000, flags=000.
// - Specials:
//   - x=0x00000000, y=0xC0A00000, op_sub=1 -> z=0x40A00000, spec=1.
//   - x=0x7F800000, any y -> z=0x7FFFFFFF, flags=101.
// - Overflow: x=y=0x7F7FFFFF, op_sub=0 -> z=0x7FFFFFFF, ovf=1.
// - Backpressure: stream 8 random pairs; hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while full, no loss or duplication, order kept, z stable.
// - Reset: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately; no stale result after release. Compare against a HUB reference model over 10k random pairs.

Source files
------------

// File: rtl/fphub_adder_pipe.sv
// Three-stage pipelined HUB floating-point adder/subtractor with valid/ready handshake.
// S1 classifies/aligns, S2 adds and counts leading zeros, S3 normalises and packs.
module fphub_adder_pipe #(
    parameter int unsigned M = 23,
    parameter int unsigned E = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] x,
    input  logic [E+M:0] y,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] z,
    output logic [2:0]   flags
);
    localparam int unsigned W  = E + M + 1;
    localparam int unsigned MW = M + 3;
    localparam int unsigned LW = $clog2(MW);
    localparam int unsigned CW = ((E > LW) ? E : LW) + 1;

    logic          adv;

    // Stage 1 registers
    logic          v1_q, v1_d, spec1_q, spec1_d, sub1_q, sub1_d, sz1_q, sz1_d;
    logic [W-1:0]  spz1_q, spz1_d;
    logic [2:0]    spf1_q, spf1_d;
    logic [E-1:0]  ez1_q, ez1_d;
    logic [MW-1:0] maj1_q, maj1_d, min1_q, min1_d;

    // Stage 2 registers
    logic          v2_q, v2_d, spec2_q, spec2_d, sub2_q, sub2_d, sz2_q, sz2_d;
    logic [W-1:0]  spz2_q, spz2_d;
    logic [2:0]    spf2_q, spf2_d;
    logic [E-1:0]  ez2_q, ez2_d;
    logic [MW-1:0] res2_q, res2_d;
    logic [LW-1:0] lz2_q, lz2_d;

    // Stage 3 (output) registers
    logic          v3_q, v3_d;
    logic [W-1:0]  z_q, z_d;
    logic [2:0]    flags_q, flags_d;

    // Combinational intermediates
    logic          sx, sy, x_zero, y_zero, x_max, y_max, x_major;
    logic [E-1:0]  ex, ey, shamt, e_inc;
    logic [M-1:0]  mx, my;
    logic [MW-1:0] maj_ext, min_ext, res;
    logic [LW-1:0] lz;
    logic [W-1:0]  z_n;
    logic [2:0]    f_n;

    assign adv       = ~v3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign z         = z_q;
    assign flags     = flags_q;

    always_comb begin
        sx      = x[W-1];
        sy      = y[W-1] ^ op_sub;
        ex      = x[W-2:M];
        ey      = y[W-2:M];
        mx      = x[M-1:0];
        my      = y[M-1:0];
        x_zero  = (ex == '0);
        y_zero  = (ey == '0);
        x_max   = (ex == '1);
        y_max   = (ey == '1);
        x_major = ({ex, mx} >= {ey, my});
        maj_ext = x_major ? {1'b0, 1'b1, mx, 1'b1} : {1'b0, 1'b1, my, 1'b1};
        min_ext = x_major ? {1'b0, 1'b1, my, 1'b1} : {1'b0, 1'b1, mx, 1'b1};
        shamt   = x_major ? (ex - ey) : (ey - ex);

        v1_d    = v1_q;
        spec1_d = spec1_q;
        spz1_d  = spz1_q;
        spf1_d  = spf1_q;
        sub1_d  = sub1_q;
        sz1_d   = sz1_q;
        ez1_d   = ez1_q;
        maj1_d  = maj1_q;
        min1_d  = min1_q;
        if (adv) begin
            v1_d    = in_valid;
            spec1_d = x_zero | y_zero | x_max | y_max;
            if (x_max | y_max) begin
                spz1_d = {(x_max ? sx : sy), {(W-1){1'b1}}};
                spf1_d = 3'b101;
            end else if (x_zero & y_zero) begin
                spz1_d = '0;
                spf1_d = 3'b001;
            end else if (x_zero) begin
                spz1_d = {sy, y[W-2:0]};
                spf1_d = 3'b001;
            end else if (y_zero) begin
                spz1_d = x;
                spf1_d = 3'b001;
            end else begin
                spz1_d = '0;
                spf1_d = 3'b000;
            end
            sub1_d = sx ^ sy;
            sz1_d  = x_major ? sx : sy;
            ez1_d  = x_major ? ex : ey;
            maj1_d = maj_ext;
            min1_d = (32'(shamt) >= MW) ? '0 : (min_ext >> shamt);
        end
    end

    // Effective subtraction always takes major - minor, so res[M+2] is 0 there
    // and the leading-zero count only needs to span res[M+1:0].
    always_comb begin
        res = sub1_q ? (maj1_q - min1_q) : (maj1_q + min1_q);
        lz  = '0;
        for (int unsigned i = 0; i < M + 2; i++) begin
            if (res[i]) lz = LW'(M + 1 - i);
        end

        v2_d    = v2_q;
        spec2_d = spec2_q;
        spz2_d  = spz2_q;
        spf2_d  = spf2_q;
        sub2_d  = sub2_q;
        sz2_d   = sz2_q;
        ez2_d   = ez2_q;
        res2_d  = res2_q;
        lz2_d   = lz2_q;
        if (adv) begin
            v2_d    = v1_q;
            spec2_d = spec1_q;
            spz2_d  = spz1_q;
            spf2_d  = spf1_q;
            sub2_d  = sub1_q;
            sz2_d   = sz1_q;
            ez2_d   = ez1_q;
            res2_d  = res;
            lz2_d   = lz;
        end
    end

    always_comb begin
        e_inc = ez2_q + 1'b1;
        z_n   = '0;
        f_n   = 3'b000;
        if (spec2_q) begin
            z_n = spz2_q;
            f_n = spf2_q;
        end else if (sub2_q) begin
            if (res2_q == '0) begin
                z_n = '0;
            end else if (CW'(ez2_q) <= CW'(lz2_q)) begin
                z_n = '0;
                f_n = 3'b010;
            end else begin
                z_n = {sz2_q, ez2_q - E'(lz2_q), M'((res2_q << lz2_q) >> 1)};
            end
        end else if (res2_q[M+2]) begin
            if (e_inc == '1) begin
                z_n = {sz2_q, {(W-1){1'b1}}};
                f_n = 3'b100;
            end else begin
                z_n = {sz2_q, e_inc, M'(res2_q >> 2)};
            end
        end else begin
            z_n = {sz2_q, ez2_q, M'(res2_q >> 1)};
        end

        v3_d    = v3_q;
        z_d     = z_q;
        flags_d = flags_q;
        if (adv) begin
            v3_d = v2_q;
            if (v2_q) begin
                z_d     = z_n;
                flags_d = f_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            spec1_q <= 1'b0;
            spz1_q  <= '0;
            spf1_q  <= '0;
            sub1_q  <= 1'b0;
            sz1_q   <= 1'b0;
            ez1_q   <= '0;
            maj1_q  <= '0;
            min1_q  <= '0;
            v2_q    <= 1'b0;
            spec2_q <= 1'b0;
            spz2_q  <= '0;
            spf2_q  <= '0;
            sub2_q  <= 1'b0;
            sz2_q   <= 1'b0;
            ez2_q   <= '0;
            res2_q  <= '0;
            lz2_q   <= '0;
            v3_q    <= 1'b0;
            z_q     <= '0;
            flags_q <= '0;
        end else begin
            v1_q    <= v1_d;
            spec1_q <= spec1_d;
            spz1_q  <= spz1_d;
            spf1_q  <= spf1_d;
            sub1_q  <= sub1_d;
            sz1_q   <= sz1_d;
            ez1_q   <= ez1_d;
            maj1_q  <= maj1_d;
            min1_q  <= min1_d;
            v2_q    <= v2_d;
            spec2_q <= spec2_d;
            spz2_q  <= spz2_d;
            spf2_q  <= spf2_d;
            sub2_q  <= sub2_d;
            sz2_q   <= sz2_d;
            ez2_q   <= ez2_d;
            res2_q  <= res2_d;
            lz2_q   <= lz2_d;
            v3_q    <= v3_d;
            z_q     <= z_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_fphub_adder_pipe.sv
// Self-checking bench for fphub_adder_pipe: directed corner cases, backpressure,
// mid-flight reset and a long randomized run against an integer HUB reference model.
module tb_fphub_adder_pipe;
    localparam int unsigned M = 23;
    localparam int unsigned E = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z;
    logic [2:0]  flags;

    fphub_adder_pipe #(.M(M), .E(E)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic [2:0]  f;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    bit          lat_chk = 1'b0;
    bit          use_dir = 1'b0;
    bit          stall_prev = 1'b0;
    bit          accepted = 1'b0;
    logic [35:0] held = '0;
    logic [31:0] dir_z = '0;
    logic [2:0]  dir_f = '0;

    localparam int ND = 12;
    logic [31:0] dx [ND] = '{32'h3F800000, 32'h40490FDB, 32'h00000000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h00800001, 32'h40400000, 32'hC1200000,
                             32'h80000000, 32'h3F800000, 32'h00000000, 32'h3F800000};
    logic [31:0] dy [ND] = '{32'h3F800000, 32'h40490FDB, 32'hC0A00000, 32'h12345678,
                             32'h7F7FFFFF, 32'h00800000, 32'h3F800000, 32'h00000000,
                             32'h00000000, 32'h7F800000, 32'hFF800000, 32'h33800000};
    logic        ds [ND] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] dz [ND] = '{32'h40000000, 32'h00000000, 32'h40A00000, 32'h7FFFFFFF,
                             32'h7FFFFFFF, 32'h00000000, 32'h40000000, 32'hC1200000,
                             32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3F800001};
    logic [2:0]  df [ND] = '{3'b000, 3'b000, 3'b001, 3'b101, 3'b100, 3'b010, 3'b000,
                             3'b001, 3'b001, 3'b101, 3'b101, 3'b000};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Value-level HUB arithmetic on integers: significand = 2^24 + 2*mant + 1.
    function automatic logic [34:0] hub_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
        logic   sa, sbn, smaj, smin;
        int     ea, eb, e, d, l;
        longint ma, mb, mmaj, mmin, r;
        sa  = a[31];
        sbn = b[31] ^ sub;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        ma  = (longint'(1) << 24) + longint'(a[22:0]) * 2 + 1;
        mb  = (longint'(1) << 24) + longint'(b[22:0]) * 2 + 1;
        if (ea == 255 || eb == 255) return {3'b101, ((ea == 255) ? sa : sbn), 31'h7FFFFFFF};
        if (ea == 0 && eb == 0) return {3'b001, 32'h0};
        if (ea == 0) return {3'b001, sbn, b[30:0]};
        if (eb == 0) return {3'b001, a};
        if (ea > eb || (ea == eb && ma >= mb)) begin
            smaj = sa;  smin = sbn; e = ea; d = ea - eb; mmaj = ma; mmin = mb;
        end else begin
            smaj = sbn; smin = sa;  e = eb; d = eb - ea; mmaj = mb; mmin = ma;
        end
        mmin = (d >= 26) ? 0 : (mmin >> d);
        if (smaj != smin) begin
            r = mmaj - mmin;
            if (r == 0) return {3'b000, 32'h0};
            l = 0;
            while (r < (longint'(1) << 24)) begin
                r = r * 2;
                l++;
            end
            if (e <= l) return {3'b010, 32'h0};
            e = e - l;
        end else begin
            r = mmaj + mmin;
            if (r >= (longint'(1) << 25)) begin
                r = r / 2;
                e++;
            end
            if (e == 255) return {3'b100, smaj, 31'h7FFFFFFF};
        end
        return {3'b000, smaj, 8'(e), 23'(r >> 1)};
    endfunction

    // Inputs are already driven at the current falling edge; sample, score, advance.
    task automatic step();
        exp_t        e;
        logic [34:0] r;
        #1;
        check("in_ready", in_ready, !out_valid || out_ready);
        if (stall_prev) check("hold_stable", {out_valid, flags, z}, held);
        stall_prev = out_valid && !out_ready;
        held = {out_valid, flags, z};
        if (out_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("z", z, e.z);
                check("flags", flags, e.f);
                if (lat_chk) check("latency", cyc - e.cyc, 3);
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            if (use_dir) begin
                e.z = dir_z;
                e.f = dir_f;
            end else begin
                r = hub_ref(x, y, op_sub);
                e.f = r[34:32];
                e.z = r[31:0];
            end
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic rand_operands();
        int          ex;
        int unsigned k;
        x      = $urandom;
        y      = $urandom;
        op_sub = 1'($urandom);
        k      = $urandom_range(0, 15);
        ex     = int'(x[30:23]);
        if (k < 4) begin
            y[30:23] = x[30:23];
        end else if (k < 8) begin
            ex = ex + int'($urandom_range(0, 6)) - 3;
            if (ex < 0) ex = 0;
            if (ex > 255) ex = 255;
            y[30:23] = 8'(ex);
        end else if (k == 8) begin
            y[30:0] = x[30:0];
        end else if (k == 9) begin
            y[30:23] = 8'h00;
        end else if (k == 10) begin
            x[30:23] = 8'hFF;
        end else if (k == 11) begin
            x[30:23] = 8'hFE;
            y[30:23] = 8'hFE;
        end else if (k == 12) begin
            x[30:23] = 8'($urandom_range(1, 3));
            y[30:23] = x[30:23];
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sent;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_z", z, 0);
        check("rst_flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed corner cases, back-to-back with a free-running consumer.
        lat_chk   = 1'b1;
        use_dir   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < ND; i++) begin
            in_valid = 1'b1;
            x = dx[i]; y = dy[i]; op_sub = ds[i];
            dir_z = dz[i]; dir_f = df[i];
            step();
        end
        drain();
        lat_chk = 1'b0;
        use_dir = 1'b0;

        // Backpressure: 8 pairs streamed, consumer stalls for 5 cycles mid-stream.
        sent = 0;
        accepted = 1'b1;
        for (int k = 0; k < 40 && sent < 8; k++) begin
            if (accepted || !in_valid) rand_operands();
            in_valid  = 1'b1;
            out_ready = !(k >= 4 && k < 9);
            step();
            if (accepted) sent++;
        end
        check("bp_sent", sent, 8);
        drain();

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_operands();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_z", z, 0);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("no_stale_out", out_valid, 0);
            step();
        end

        // Long randomized run with random producer gaps and consumer stalls.
        sent = 0;
        accepted = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 40000 && sent < 10000; k++) begin
            if (accepted || !in_valid) begin
                in_valid = ($urandom_range(0, 9) < 8);
                rand_operands();
            end
            out_ready = ($urandom_range(0, 9) < 8);
            step();
            if (accepted) sent++;
        end
        check("rand_sent", sent, 10000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
